hazard_stall_ctrl: RTL

- Stall/flush controller for the five-stage pipeline.
- Decides each cycle whether F and D hold, and whether a bubble (nop) enters the D->E register.
- Owns the multiply/divide busy sequencer, so instructions that touch HI/LO wait in D until the MDU result is ready.
- Sits beside the D stage. Drives the write-enables of the F/D registers and the clear input of the D->E register.

---
 rtl/hazard_stall_ctrl_pkg.sv | 31 +++
 rtl/md_busy_seq.sv | 52 +++++
 rtl/hazard_stall_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: TUSE/TNEW
// encodings, default MDU latencies and the hard-wired zero register index.
package hazard_stall_ctrl_pkg;

    // TUSE / TNEW encoding: 0..2 are real distances in cycles; 3 means the
    // operand is not read (TUSE) so no producer can ever be "too late" for it.
    localparam logic [1:0] T_NOW  = 2'd0;
    localparam logic [1:0] T_ONE  = 2'd1;
    localparam logic [1:0] T_TWO  = 2'd2;
    localparam logic [1:0] T_NONE = 2'd3;

    // Default multiply/divide unit latencies, in busy cycles.
    localparam int MULT_CYCLES_D = 5;
    localparam int DIV_CYCLES_D  = 10;

    // $zero is never a real dependency.
    localparam logic [4:0] ZERO_REG = 5'd0;

    // True when the instruction in D must wait for one producer: it reads a
    // real register that the producer writes, and the producer's result
    // becomes forwardable later than D needs it.
    function automatic logic data_hazard(
        input logic [4:0] src,
        input logic [1:0] tuse,
        input logic [4:0] wa,
        input logic [1:0] tnew
    );
        return (src != ZERO_REG) && (src == wa) && (tnew > tuse);
    endfunction

endpackage

// File: rtl/md_busy_seq.sv
// Multiply/divide busy sequencer. Loads a down-counter when an MDU operation
// starts in E and reports md_busy while it runs, plus a registered one-cycle
// md_done pulse on the first idle cycle after the operation.
module md_busy_seq
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_D,
    parameter int DIV_CYCLES  = DIV_CYCLES_D,
    parameter int CNT_W       = 4
) (
    input  logic clk,
    input  logic res,
    input  logic start,
    input  logic is_div,
    output logic md_busy,
    output logic md_done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Next count: a running operation always counts down and ignores new
    // starts; only an idle unit accepts a start (including in the md_done cycle).
    always_comb begin
        // NOTE: assign the default first so every path drives cnt_next and no latch is inferred.
        cnt_next = cnt;
        if (cnt != '0) begin
            cnt_next = cnt - CNT_ONE;
        end else if (start) begin
            cnt_next = is_div ? DIV_LOAD : MULT_LOAD;
        end
    end

    // Counter and done-pulse registers, cleared asynchronously by res.
    always_ff @(posedge clk or posedge res) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (res) begin
            cnt     <= '0;
            md_done <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            md_done <= (cnt == CNT_ONE);
        end
    end

    assign md_busy = (cnt != '0);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the five-stage pipeline. Detects RAW hazards
// between D and the E/M producers using TUSE/TNEW, holds D while the MDU is
// busy, and drives the F/D write enables and the D->E bubble clear.
// Optional build macro HAZARD_STALL_STATS_EN adds a saturating stall-cycle
// counter output stall_cycles.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_D,
    parameter int DIV_CYCLES  = DIV_CYCLES_D,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_tuse_rs,
    input  logic [1:0]  D_tuse_rt,
    input  logic        D_is_md,
    input  logic [4:0]  E_wa,
    input  logic [1:0]  E_tnew,
    input  logic [4:0]  M_wa,
    input  logic [1:0]  M_tnew,
    input  logic        E_md_start,
    input  logic        E_md_is_div,
    output logic        stall,
    output logic        F_WE,
    output logic        D_WE,
    output logic        E_clr,
    output logic        md_busy,
    output logic        md_done
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    logic hz_rs_e;
    logic hz_rs_m;
    logic hz_rt_e;
    logic hz_rt_m;
    logic hz_data;
    logic hz_md;

    md_busy_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_seq (
        .clk     (clk),
        .res     (res),
        .start   (E_md_start),
        .is_div  (E_md_is_div),
        .md_busy (md_busy),
        .md_done (md_done)
    );

    // Hazard detection and pipeline control; purely combinational so a stall
    // takes effect in the same cycle the conflict appears.
    always_comb begin
        hz_rs_e = data_hazard(D_rs_addr, D_tuse_rs, E_wa, E_tnew);
        hz_rs_m = data_hazard(D_rs_addr, D_tuse_rs, M_wa, M_tnew);
        hz_rt_e = data_hazard(D_rt_addr, D_tuse_rt, E_wa, E_tnew);
        hz_rt_m = data_hazard(D_rt_addr, D_tuse_rt, M_wa, M_tnew);
        hz_data = hz_rs_e | hz_rs_m | hz_rt_e | hz_rt_m;
        // A start in E counts as busy already: HI/LO are stale from this cycle.
        hz_md   = D_is_md & (md_busy | E_md_start);

        stall = hz_data | hz_md;
        F_WE  = ~stall;
        D_WE  = ~stall;
        E_clr = stall;
    end

`ifdef HAZARD_STALL_STATS_EN
    // Saturating count of stalled clock edges, for performance monitoring.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            stall_cycles <= 32'd0;
        end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule
